// File: rtl/gift_ise_arb.sv
// rtl/gift_ise_arb.sv - two-requester arbiter and response buffer for the shared GIFT ISE datapath
module gift_ise_arb #(
    parameter logic       PRIO0      = 1'b0,
    parameter logic [3:0] STARVE_MAX = 4'd8
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        rq0_val,
    output logic        rq0_rdy,
    input  logic [5:0]  rq0_fn,
    input  logic [6:0]  rq0_imm,
    input  logic [31:0] rq0_in1,
    input  logic [31:0] rq0_in2,
    input  logic        rq1_val,
    output logic        rq1_rdy,
    input  logic [5:0]  rq1_fn,
    input  logic [6:0]  rq1_imm,
    input  logic [31:0] rq1_in1,
    input  logic [31:0] rq1_in2,
    output logic        rs0_val,
    input  logic        rs0_rdy,
    output logic [31:0] rs0_data,
    output logic        rs0_err,
    output logic        rs1_val,
    input  logic        rs1_rdy,
    output logic [31:0] rs1_data,
    output logic        rs1_err,
    output logic [5:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    output logic        ise_val,
    input  logic        ise_oval,
    input  logic [31:0] ise_out,
    output logic        busy
);

    logic        elig0;
    logic        elig1;
    logic        pick1;
    logic        gnt0;
    logic        gnt1;
    logic        rr_ptr;
    logic [3:0]  starve_cnt;
    logic [31:0] cap_data;

    // Eligibility, winner selection and the issue mux towards the ISE
    always_comb begin
        elig0 = rq0_val & (~rs0_val | rs0_rdy);
        elig1 = rq1_val & (~rs1_val | rs1_rdy);
        pick1 = elig1;
        if (elig0 && elig1) begin
            if (PRIO0) begin
                pick1 = (starve_cnt >= STARVE_MAX);
            end else begin
                pick1 = rr_ptr;
            end
        end
        gnt0    = elig0 & ~pick1;
        gnt1    = elig1 & pick1;
        ise_val = gnt0 | gnt1;
        ise_fn  = '0;
        ise_imm = '0;
        ise_in1 = '0;
        ise_in2 = '0;
        if (gnt1) begin
            ise_fn  = rq1_fn;
            ise_imm = rq1_imm;
            ise_in1 = rq1_in1;
            ise_in2 = rq1_in2;
        end else if (gnt0) begin
            ise_fn  = rq0_fn;
            ise_imm = rq0_imm;
            ise_in1 = rq0_in1;
            ise_in2 = rq0_in2;
        end
    end

    assign rq0_rdy  = gnt0;
    assign rq1_rdy  = gnt1;
    assign busy     = rs0_val | rs1_val;
    // An undecoded op never leaks ISE output into the response register
    assign cap_data = ise_oval ? ise_out : 32'd0;

    // Round-robin pointer and fixed-priority starvation counter
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            rr_ptr     <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if (gnt0) begin
                rr_ptr <= 1'b1;
            end else if (gnt1) begin
                rr_ptr <= 1'b0;
            end
            if (PRIO0) begin
                if (gnt1 || !elig1) begin
                    starve_cnt <= 4'd0;
                end else if (gnt0 && (starve_cnt < STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

    // Requester 0 response slot: load on grant, drop on consumption
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            rs0_val  <= 1'b0;
            rs0_data <= 32'd0;
            rs0_err  <= 1'b0;
        end else if (gnt0) begin
            rs0_val  <= 1'b1;
            rs0_data <= cap_data;
            rs0_err  <= ~ise_oval;
        end else if (rs0_rdy) begin
            rs0_val  <= 1'b0;
        end
    end

    // Requester 1 response slot: load on grant, drop on consumption
    always_ff @(posedge ise_clk or negedge ise_rst) begin
        if (!ise_rst) begin
            rs1_val  <= 1'b0;
            rs1_data <= 32'd0;
            rs1_err  <= 1'b0;
        end else if (gnt1) begin
            rs1_val  <= 1'b1;
            rs1_data <= cap_data;
            rs1_err  <= ~ise_oval;
        end else if (rs1_rdy) begin
            rs1_val  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gift_ise_arb.sv
// tb/tb_gift_ise_arb.sv - scoreboard bench for gift_ise_arb (round-robin and fixed-priority instances)
module tb_gift_ise_arb;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        rq0_val, rq0_rdy, rq1_val, rq1_rdy;
    logic [5:0]  rq0_fn, rq1_fn;
    logic [6:0]  rq0_imm, rq1_imm;
    logic [31:0] rq0_in1, rq0_in2, rq1_in1, rq1_in2;
    logic        rs0_val, rs0_rdy, rs0_err, rs1_val, rs1_rdy, rs1_err;
    logic [31:0] rs0_data, rs1_data;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1, ise_in2, ise_out;
    logic        ise_val, ise_oval, busy;

    logic        pb_rq0_val, pb_rq0_rdy, pb_rq1_val, pb_rq1_rdy;
    logic        pb_rs0_val, pb_rs0_err, pb_rs1_val, pb_rs1_err;
    logic [31:0] pb_rs0_data, pb_rs1_data;
    logic [5:0]  pb_ise_fn;
    logic [6:0]  pb_ise_imm;
    logic [31:0] pb_ise_in1, pb_ise_in2;
    logic        pb_ise_val, pb_busy;

    int    n_cmp = 0;
    int    n_bad = 0;
    resp_t q0[$];
    resp_t q1[$];
    logic  pend0 = 1'b0;
    logic  pend1 = 1'b0;

    // Reference ISE: imm[6] set means "not decoded"
    function automatic logic [31:0] model_out(input logic [5:0] fn, input logic [6:0] imm,
                                               input logic [31:0] in1, input logic [31:0] in2);
        if (imm[6]) return 32'hFFFFFFFF;
        return (in1 ^ {in2[15:0], in2[31:16]}) + {26'd0, fn} + {25'd0, imm};
    endfunction

    function automatic resp_t model_resp(input logic [5:0] fn, input logic [6:0] imm,
                                         input logic [31:0] in1, input logic [31:0] in2);
        resp_t r;
        r.err  = imm[6];
        r.data = imm[6] ? 32'd0 : model_out(fn, imm, in1, in2);
        return r;
    endfunction

    assign ise_oval = ~ise_imm[6];
    assign ise_out  = model_out(ise_fn, ise_imm, ise_in1, ise_in2);

    gift_ise_arb #(.PRIO0(1'b0), .STARVE_MAX(4'd8)) dut (
        .ise_clk(clk), .ise_rst(rst),
        .rq0_val(rq0_val), .rq0_rdy(rq0_rdy), .rq0_fn(rq0_fn), .rq0_imm(rq0_imm),
        .rq0_in1(rq0_in1), .rq0_in2(rq0_in2),
        .rq1_val(rq1_val), .rq1_rdy(rq1_rdy), .rq1_fn(rq1_fn), .rq1_imm(rq1_imm),
        .rq1_in1(rq1_in1), .rq1_in2(rq1_in2),
        .rs0_val(rs0_val), .rs0_rdy(rs0_rdy), .rs0_data(rs0_data), .rs0_err(rs0_err),
        .rs1_val(rs1_val), .rs1_rdy(rs1_rdy), .rs1_data(rs1_data), .rs1_err(rs1_err),
        .ise_fn(ise_fn), .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2),
        .ise_val(ise_val), .ise_oval(ise_oval), .ise_out(ise_out), .busy(busy)
    );

    gift_ise_arb #(.PRIO0(1'b1), .STARVE_MAX(4'd3)) dut_prio (
        .ise_clk(clk), .ise_rst(rst),
        .rq0_val(pb_rq0_val), .rq0_rdy(pb_rq0_rdy), .rq0_fn(6'd1), .rq0_imm(7'd2),
        .rq0_in1(32'h00000010), .rq0_in2(32'h00000020),
        .rq1_val(pb_rq1_val), .rq1_rdy(pb_rq1_rdy), .rq1_fn(6'd3), .rq1_imm(7'd4),
        .rq1_in1(32'h00000030), .rq1_in2(32'h00000040),
        .rs0_val(pb_rs0_val), .rs0_rdy(1'b1), .rs0_data(pb_rs0_data), .rs0_err(pb_rs0_err),
        .rs1_val(pb_rs1_val), .rs1_rdy(1'b1), .rs1_data(pb_rs1_data), .rs1_err(pb_rs1_err),
        .ise_fn(pb_ise_fn), .ise_imm(pb_ise_imm), .ise_in1(pb_ise_in1), .ise_in2(pb_ise_in2),
        .ise_val(pb_ise_val), .ise_oval(1'b1), .ise_out(pb_ise_in1), .busy(pb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Negedge sample: retire the previous cycle's grants, record this cycle's
    task automatic sample();
        resp_t e;
        @(negedge clk);
        if (pend0) begin
            e = q0.pop_front();
            chk("rs0_val", {31'd0, rs0_val}, 32'd1);
            chk("rs0_data", rs0_data, e.data);
            chk("rs0_err", {31'd0, rs0_err}, {31'd0, e.err});
        end
        if (pend1) begin
            e = q1.pop_front();
            chk("rs1_val", {31'd0, rs1_val}, 32'd1);
            chk("rs1_data", rs1_data, e.data);
            chk("rs1_err", {31'd0, rs1_err}, {31'd0, e.err});
        end
        pend0 = rq0_rdy;
        pend1 = rq1_rdy;
        if (rq0_rdy) q0.push_back(model_resp(rq0_fn, rq0_imm, rq0_in1, rq0_in2));
        if (rq1_rdy) q1.push_back(model_resp(rq1_fn, rq1_imm, rq1_in1, rq1_in2));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        gr0, gr1;
        logic [31:0] hold;
        int          g0c, g1c;

        rst = 1'b0;
        rq0_val = 1'b0; rq0_fn = '0; rq0_imm = '0; rq0_in1 = '0; rq0_in2 = '0;
        rq1_val = 1'b0; rq1_fn = '0; rq1_imm = '0; rq1_in1 = '0; rq1_in2 = '0;
        rs0_rdy = 1'b1; rs1_rdy = 1'b1;
        pb_rq0_val = 1'b0; pb_rq1_val = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rs0_val", {31'd0, rs0_val}, 32'd0);
        chk("rst_rs1_val", {31'd0, rs1_val}, 32'd0);
        chk("rst_rs0_data", rs0_data, 32'd0);
        chk("rst_rs1_err", {31'd0, rs1_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ise_val", {31'd0, ise_val}, 32'd0);
        rst = 1'b1;

        // Fixed priority, STARVE_MAX = 3: pattern 0,0,0,1 repeating
        pb_rq0_val = 1'b1; pb_rq1_val = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample();
            chk("prio_gnt0", {31'd0, pb_rq0_rdy}, (i % 4 != 3) ? 32'd1 : 32'd0);
            chk("prio_gnt1", {31'd0, pb_rq1_rdy}, (i % 4 == 3) ? 32'd1 : 32'd0);
            adv();
        end
        pb_rq0_val = 1'b0; pb_rq1_val = 1'b0;

        // Single decoded op on requester 0
        rq0_fn = 6'b000000; rq0_imm = 7'b0100000; rq0_in1 = 32'h01234567; rq0_in2 = 32'h89ABCDEF;
        rq0_val = 1'b1;
        sample();
        chk("single_ise_val", {31'd0, ise_val}, 32'd1);
        chk("single_rq0_rdy", {31'd0, rq0_rdy}, 32'd1);
        chk("single_rq1_rdy", {31'd0, rq1_rdy}, 32'd0);
        chk("single_ise_in1", ise_in1, 32'h01234567);
        chk("single_ise_imm", {25'd0, ise_imm}, 32'h20);
        adv();
        rq0_val = 1'b0;
        sample();
        chk("single_rs0_err", {31'd0, rs0_err}, 32'd0);
        chk("idle_ise_val", {31'd0, ise_val}, 32'd0);
        chk("idle_ise_in1", ise_in1, 32'd0);
        chk("idle_ise_fn", {26'd0, ise_fn}, 32'd0);
        adv();
        sample();
        chk("single_drained", {31'd0, rs0_val}, 32'd0);
        chk("single_busy", {31'd0, busy}, 32'd0);
        adv();

        // Undecoded op on requester 1
        rq1_fn = 6'b000011; rq1_imm = 7'b1000000; rq1_in1 = 32'hDEADBEEF; rq1_in2 = 32'h0BADF00D;
        rq1_val = 1'b1;
        sample();
        chk("undec_rq1_rdy", {31'd0, rq1_rdy}, 32'd1);
        adv();
        rq1_val = 1'b0;
        sample();
        chk("undec_rs1_err", {31'd0, rs1_err}, 32'd1);
        chk("undec_rs1_data", rs1_data, 32'd0);
        chk("undec_busy", {31'd0, busy}, 32'd1);
        adv();

        // Round-robin, both valid, both responses consumed every cycle
        rq0_fn = 6'd5; rq0_imm = 7'd9;  rq0_in1 = 32'h10203040; rq0_in2 = 32'hA5A5A5A5;
        rq1_fn = 6'd7; rq1_imm = 7'd17; rq1_in1 = 32'hCAFEF00D; rq1_in2 = 32'h13579BDF;
        rq0_val = 1'b1; rq1_val = 1'b1;
        g0c = 0; g1c = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("rr_gnt0", {31'd0, rq0_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", {31'd0, rq1_rdy}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_rs0_val", {31'd0, rs0_val}, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_rs1_val", {31'd0, rs1_val}, (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
            g0c += int'(rq0_rdy);
            g1c += int'(rq1_rdy);
            gr0 = rq0_rdy; gr1 = rq1_rdy;
            adv();
            if (gr0) rq0_in1 = rq0_in1 + 32'h11111111;
            if (gr1) rq1_in2 = rq1_in2 ^ 32'h0F0F0F0F;
        end
        chk("rr_count0", g0c, 32'd4);
        chk("rr_count1", g1c, 32'd4);
        rq0_val = 1'b0; rq1_val = 1'b0;
        sample(); adv();
        sample(); adv();

        // Backpressure on requester 0 while requester 1 keeps flowing
        rs0_rdy = 1'b0;
        rq0_val = 1'b1; rq1_val = 1'b1;
        sample();
        chk("bp_first_gnt0", {31'd0, rq0_rdy}, 32'd1);
        adv();
        rq0_in1 = 32'h55AA55AA; rq0_imm = 7'd33;
        sample();
        chk("bp_stall0", {31'd0, rq0_rdy}, 32'd0);
        chk("bp_serve1", {31'd0, rq1_rdy}, 32'd1);
        hold = rs0_data;
        adv();
        rq1_in1 = rq1_in1 + 32'd1;
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("bp_stall0", {31'd0, rq0_rdy}, 32'd0);
            chk("bp_serve1", {31'd0, rq1_rdy}, 32'd1);
            chk("bp_hold_data", rs0_data, hold);
            chk("bp_hold_val", {31'd0, rs0_val}, 32'd1);
            adv();
            rq1_in1 = rq1_in1 + 32'd1;
        end
        rs0_rdy = 1'b1;
        sample();
        chk("bp_release_gnt0", {31'd0, rq0_rdy}, 32'd1);
        adv();
        rq0_val = 1'b0; rq1_val = 1'b0;
        sample(); adv();
        sample(); adv();

        // Reset while a captured result is held
        rs0_rdy = 1'b0;
        rq0_fn = 6'd2; rq0_imm = 7'd3; rq0_in1 = 32'h7777AAAA; rq0_in2 = 32'h12345678;
        rq0_val = 1'b1;
        sample();
        chk("mid_gnt0", {31'd0, rq0_rdy}, 32'd1);
        adv();
        rq0_val = 1'b0;
        chk("mid_pre_val", {31'd0, rs0_val}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_val", {31'd0, rs0_val}, 32'd0);
        chk("mid_rst_data", rs0_data, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        pend0 = 1'b0; pend1 = 1'b0;
        q0.delete(); q1.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rs0_rdy = 1'b1;
        rq0_val = 1'b1; rq1_val = 1'b1;
        sample();
        chk("post_rst_gnt0", {31'd0, rq0_rdy}, 32'd1);
        chk("post_rst_gnt1", {31'd0, rq1_rdy}, 32'd0);
        adv();
        rq0_val = 1'b0; rq1_val = 1'b0;
        sample(); adv();
        sample(); adv();
        chk("sb_empty", q0.size() + q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
